// File: rtl/state_key_loader_if.sv
// Handshake and matrix bus between the byte-serial loader and its upstream/downstream stages.
// The slave modport is the loader side; the master modport is the environment side.
interface state_key_loader_if;
  logic       abort;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] data_byte;
  logic [7:0] key_byte;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] fill_count;
  logic [7:0] data_row1_col1, data_row2_col1, data_row3_col1, data_row4_col1;
  logic [7:0] data_row1_col2, data_row2_col2, data_row3_col2, data_row4_col2;
  logic [7:0] data_row1_col3, data_row2_col3, data_row3_col3, data_row4_col3;
  logic [7:0] data_row1_col4, data_row2_col4, data_row3_col4, data_row4_col4;
  logic [7:0] key_row1_col1, key_row2_col1, key_row3_col1, key_row4_col1;
  logic [7:0] key_row1_col2, key_row2_col2, key_row3_col2, key_row4_col2;
  logic [7:0] key_row1_col3, key_row2_col3, key_row3_col3, key_row4_col3;
  logic [7:0] key_row1_col4, key_row2_col4, key_row3_col4, key_row4_col4;

  modport slave (
    input  abort, in_valid, data_byte, key_byte, out_ready,
    output in_ready, out_valid, fill_count,
    output data_row1_col1, data_row2_col1, data_row3_col1, data_row4_col1,
    output data_row1_col2, data_row2_col2, data_row3_col2, data_row4_col2,
    output data_row1_col3, data_row2_col3, data_row3_col3, data_row4_col3,
    output data_row1_col4, data_row2_col4, data_row3_col4, data_row4_col4,
    output key_row1_col1, key_row2_col1, key_row3_col1, key_row4_col1,
    output key_row1_col2, key_row2_col2, key_row3_col2, key_row4_col2,
    output key_row1_col3, key_row2_col3, key_row3_col3, key_row4_col3,
    output key_row1_col4, key_row2_col4, key_row3_col4, key_row4_col4
  );

  modport master (
    output abort, in_valid, data_byte, key_byte, out_ready,
    input  in_ready, out_valid, fill_count,
    input  data_row1_col1, data_row2_col1, data_row3_col1, data_row4_col1,
    input  data_row1_col2, data_row2_col2, data_row3_col2, data_row4_col2,
    input  data_row1_col3, data_row2_col3, data_row3_col3, data_row4_col3,
    input  data_row1_col4, data_row2_col4, data_row3_col4, data_row4_col4,
    input  key_row1_col1, key_row2_col1, key_row3_col1, key_row4_col1,
    input  key_row1_col2, key_row2_col2, key_row3_col2, key_row4_col2,
    input  key_row1_col3, key_row2_col3, key_row3_col3, key_row4_col3,
    input  key_row1_col4, key_row2_col4, key_row3_col4, key_row4_col4
  );
endinterface

// File: rtl/state_key_loader.sv
// Byte-serial loader assembling 4x4 data and key matrices (AES column-major) for AddRoundKey.
// Presents both matrices in parallel and holds them until the downstream handshake.
module state_key_loader #(
  parameter bit CLEAR_ON_ACCEPT = 1'b1
) (
  input logic               clk,
  input logic               rst_n,
  state_key_loader_if.slave bus
);
  typedef enum logic {FILL, FULL} state_t;

  state_t     state, state_nx;
  logic [4:0] fill_q, fill_nx;
  logic       in_ready_q, out_valid_q;
  logic       accept, transfer, wr_en, clr;
  logic [7:0] data_m [16];
  logic [7:0] key_m  [16];

  // Storage index is the stream index k, so k = (col-1)*4 + (row-1).
  always_comb begin
    state_nx = state;
    fill_nx  = fill_q;
    wr_en    = 1'b0;
    clr      = 1'b0;
    accept   = bus.in_valid & in_ready_q;
    transfer = out_valid_q & bus.out_ready;
    if (bus.abort) begin
      state_nx = FILL;
      fill_nx  = '0;
      clr      = 1'b1;
    end else begin
      case (state)
        FILL: if (accept) begin
          wr_en   = 1'b1;
          fill_nx = fill_q + 5'd1;
          if (fill_q == 5'd15) state_nx = FULL;
        end
        FULL: if (transfer) begin
          state_nx = FILL;
          fill_nx  = '0;
          clr      = CLEAR_ON_ACCEPT;
        end
        default: state_nx = FILL;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= FILL;
      fill_q      <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      for (int unsigned i = 0; i < 16; i++) begin
        data_m[i] <= '0;
        key_m[i]  <= '0;
      end
    end else begin
      state       <= state_nx;
      fill_q      <= fill_nx;
      in_ready_q  <= (state_nx == FILL);
      out_valid_q <= (state_nx == FULL);
      if (clr) begin
        for (int unsigned i = 0; i < 16; i++) begin
          data_m[i] <= '0;
          key_m[i]  <= '0;
        end
      end else if (wr_en) begin
        data_m[fill_q[3:0]] <= bus.data_byte;
        key_m[fill_q[3:0]]  <= bus.key_byte;
      end
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.fill_count = fill_q;

  assign bus.data_row1_col1 = data_m[0];
  assign bus.data_row2_col1 = data_m[1];
  assign bus.data_row3_col1 = data_m[2];
  assign bus.data_row4_col1 = data_m[3];
  assign bus.data_row1_col2 = data_m[4];
  assign bus.data_row2_col2 = data_m[5];
  assign bus.data_row3_col2 = data_m[6];
  assign bus.data_row4_col2 = data_m[7];
  assign bus.data_row1_col3 = data_m[8];
  assign bus.data_row2_col3 = data_m[9];
  assign bus.data_row3_col3 = data_m[10];
  assign bus.data_row4_col3 = data_m[11];
  assign bus.data_row1_col4 = data_m[12];
  assign bus.data_row2_col4 = data_m[13];
  assign bus.data_row3_col4 = data_m[14];
  assign bus.data_row4_col4 = data_m[15];

  assign bus.key_row1_col1 = key_m[0];
  assign bus.key_row2_col1 = key_m[1];
  assign bus.key_row3_col1 = key_m[2];
  assign bus.key_row4_col1 = key_m[3];
  assign bus.key_row1_col2 = key_m[4];
  assign bus.key_row2_col2 = key_m[5];
  assign bus.key_row3_col2 = key_m[6];
  assign bus.key_row4_col2 = key_m[7];
  assign bus.key_row1_col3 = key_m[8];
  assign bus.key_row2_col3 = key_m[9];
  assign bus.key_row3_col3 = key_m[10];
  assign bus.key_row4_col3 = key_m[11];
  assign bus.key_row1_col4 = key_m[12];
  assign bus.key_row2_col4 = key_m[13];
  assign bus.key_row3_col4 = key_m[14];
  assign bus.key_row4_col4 = key_m[15];
endmodule
